// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run/pause/done sequencer around a modulo counter.
// A run latches a modulus and a wrap target when it starts. It counts
// modulo that modulus, and it finishes after the target number of wraps
// unless the target is 0, which means free-run.
module counter_seq_ctrl #(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic [CNT_W-1:0]  mod_m,
    input  logic [WRAP_W-1:0] n_wraps,
    output logic              enable_out,
    output logic [CNT_W-1:0]  count,
    output logic              carry_out,
    output logic [WRAP_W-1:0] wraps,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = 1;

    state_t              st;
    logic [CNT_W-1:0]    m_lat;
    logic [WRAP_W-1:0]   n_lat;
    logic [CNT_W-1:0]    m_last;
    logic                last_wrap;
    logic                term;

    // A modulus of 0 wraps around to all-ones, which gives the full 2^CNT_W range.
    assign m_last    = m_lat - CNT_ONE;
    assign carry_out = (st == RUN) && (count == m_last);
    // The test uses >= rather than == so that a run that was paused on its
    // terminal carry (wraps already at n_lat) still ends on its next carry.
    assign last_wrap = (n_lat != '0) && (wraps >= n_lat - WRAP_ONE);
    assign term      = carry_out && last_wrap;
    assign state     = st;

    // Sequencer: priority is stop > pause > start; the status flags are registered next to the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            count      <= '0;
            wraps      <= '0;
            m_lat      <= '0;
            n_lat      <= '0;
            enable_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (stop) begin
            st                       <= IDLE;
            count                    <= '0;
            wraps                    <= '0;
            {enable_out, busy, done} <= 3'b000;
        end else begin
            case (st)
                IDLE, DONE: begin
                    if (start) begin
                        m_lat                    <= mod_m;
                        n_lat                    <= n_wraps;
                        count                    <= '0;
                        wraps                    <= '0;
                        st                       <= RUN;
                        {enable_out, busy, done} <= 3'b110;
                    end
                end
                RUN: begin
                    // The count step still happens on the edge where pause takes effect.
                    if (term) begin
                        count <= '0;
                        wraps <= n_lat;
                    end else if (carry_out) begin
                        count <= '0;
                        wraps <= wraps + WRAP_ONE;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                    if (pause) begin
                        st                       <= PAUSE;
                        {enable_out, busy, done} <= 3'b010;
                    end else if (term) begin
                        st                       <= DONE;
                        {enable_out, busy, done} <= 3'b001;
                    end
                end
                PAUSE: begin
                    // Resume keeps the latched settings, the count and the wrap total.
                    if (!pause && start) begin
                        st                       <= RUN;
                        {enable_out, busy, done} <= 3'b110;
                    end
                end
                default: begin
                    st                       <= IDLE;
                    {enable_out, busy, done} <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: a vector table, then hand-written
// sequences for the long runs, pause/resume and asynchronous reset.
module tb_counter_seq_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_DONE = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, pause, stop;
    logic [3:0] mod_m;
    logic [7:0] n_wraps;
    logic       enable_out, carry_out, busy, done;
    logic [3:0] count;
    logic [7:0] wraps;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       st, pa, sp;
        logic [3:0] m;
        logic [7:0] n;
        logic [1:0] es;
        logic [3:0] ec;
        logic [7:0] ew;
        logic       ecar;
    } vec_t;

    vec_t vq[$];

    counter_seq_ctrl #(.CNT_W(4), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .mod_m(mod_m), .n_wraps(n_wraps), .enable_out(enable_out), .count(count),
        .carry_out(carry_out), .wraps(wraps), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic add(input logic st, input logic pa, input logic sp, input logic [3:0] m,
                       input logic [7:0] n, input logic [1:0] es, input logic [3:0] ec,
                       input logic [7:0] ew, input logic ecar);
        vec_t v;
        v.st = st; v.pa = pa; v.sp = sp; v.m = m; v.n = n;
        v.es = es; v.ec = ec; v.ew = ew; v.ecar = ecar;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [1:0] es, input logic [3:0] ec,
                       input logic [7:0] ew, input logic ecar);
        logic [17:0] exp_v, act_v;
        exp_v = {es, es == S_RUN, (es == S_RUN) || (es == S_PAUSE), es == S_DONE, ecar, ec, ew};
        act_v = {state, enable_out, busy, done, carry_out, count, wraps};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got st=%b en=%b busy=%b done=%b carry=%b cnt=%0d wraps=%0d, want st=%b en=%b busy=%b done=%b carry=%b cnt=%0d wraps=%0d",
                     name, act_v[17:16], act_v[15], act_v[14], act_v[13], act_v[12], act_v[11:8], act_v[7:0],
                     exp_v[17:16], exp_v[15], exp_v[14], exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic pa, input logic sp, input logic [3:0] m, input logic [7:0] n);
        start = st; pause = pa; stop = sp; mod_m = m; n_wraps = n;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        #2;
        chk("reset_state", S_IDLE, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // st pa sp  m  n   | state   cnt wraps carry
        add(1, 0, 0, 5, 2,  S_RUN,   0, 0, 0);  // start mod 5, 2 wraps
        add(0, 0, 0, 9, 7,  S_RUN,   1, 0, 0);  // mod_m/n_wraps changes ignored
        add(0, 0, 0, 9, 7,  S_RUN,   2, 0, 0);
        add(1, 0, 0, 3, 3,  S_RUN,   3, 0, 0);  // start in RUN ignored
        add(0, 0, 0, 0, 0,  S_RUN,   4, 0, 1);
        add(0, 0, 0, 0, 0,  S_RUN,   0, 1, 0);
        add(0, 0, 0, 0, 0,  S_RUN,   1, 1, 0);
        add(0, 0, 0, 0, 0,  S_RUN,   2, 1, 0);
        add(0, 0, 0, 0, 0,  S_RUN,   3, 1, 0);
        add(0, 0, 0, 0, 0,  S_RUN,   4, 1, 1);
        add(0, 0, 0, 0, 0,  S_DONE,  0, 2, 0);  // done after 10 RUN edges
        add(0, 1, 0, 0, 0,  S_DONE,  0, 2, 0);  // pause in DONE ignored
        add(0, 0, 0, 0, 0,  S_DONE,  0, 2, 0);
        add(1, 0, 0, 1, 0,  S_RUN,   0, 0, 1);  // mod 1: carry every cycle
        add(0, 0, 0, 0, 0,  S_RUN,   0, 1, 1);
        add(0, 0, 0, 0, 0,  S_RUN,   0, 2, 1);
        add(0, 1, 0, 0, 0,  S_PAUSE, 0, 3, 0);
        add(0, 1, 0, 0, 0,  S_PAUSE, 0, 3, 0);
        add(1, 1, 0, 0, 0,  S_PAUSE, 0, 3, 0);  // pause beats start
        add(1, 0, 0, 0, 0,  S_RUN,   0, 3, 1);  // resume, no clear
        add(0, 0, 1, 0, 0,  S_IDLE,  0, 0, 0);
        add(0, 1, 0, 0, 0,  S_IDLE,  0, 0, 0);  // pause in IDLE ignored
        add(1, 1, 1, 4, 4,  S_IDLE,  0, 0, 0);  // stop beats start in IDLE
        add(1, 0, 0, 3, 1,  S_RUN,   0, 0, 0);
        add(0, 0, 0, 0, 0,  S_RUN,   1, 0, 0);
        add(0, 0, 0, 0, 0,  S_RUN,   2, 0, 1);  // terminal carry pending
        add(0, 1, 0, 0, 0,  S_PAUSE, 0, 1, 0);  // pause wins over DONE
        add(1, 0, 0, 0, 0,  S_RUN,   0, 1, 0);
        add(0, 0, 0, 0, 0,  S_RUN,   1, 1, 0);
        add(0, 0, 0, 0, 0,  S_RUN,   2, 1, 1);
        add(0, 0, 0, 0, 0,  S_DONE,  0, 1, 0);  // next terminal carry ends run
        add(1, 1, 1, 0, 0,  S_IDLE,  0, 0, 0);  // stop from DONE clears

        foreach (vq[i]) begin
            drive(vq[i].st, vq[i].pa, vq[i].sp, vq[i].m, vq[i].n);
            step();
            chk($sformatf("vec%0d", i), vq[i].es, vq[i].ec, vq[i].ew, vq[i].ecar);
        end

        // Full-range modulus with a single wrap
        drive(1, 0, 0, 0, 1);
        step(); chk("m0_start", S_RUN, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("m0_cnt%0d", i), S_RUN, 4'(i), 0, i == 15);
        end
        step(); chk("m0_done", S_DONE, 0, 1, 0);
        drive(0, 0, 1, 0, 0);
        step(); chk("m0_stop", S_IDLE, 0, 0, 0);

        // Free-run wrap counter rolls over modulo 256
        drive(1, 0, 0, 1, 0);
        step(); chk("free_start", S_RUN, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        repeat (255) step();
        chk("free_255", S_RUN, 0, 255, 1);
        step(); chk("free_roll", S_RUN, 0, 0, 1);
        drive(0, 0, 1, 0, 0);
        step(); chk("free_stop1", S_IDLE, 0, 0, 0);

        // Free-run mod 5 for 15 edges, then stop
        drive(1, 0, 0, 5, 0);
        step(); chk("m5_start", S_RUN, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (15) step();
        chk("m5_15edges", S_RUN, 0, 3, 0);
        drive(0, 0, 1, 0, 0);
        step(); chk("m5_stop", S_IDLE, 0, 0, 0);

        // Latency, pause hold and resume
        drive(1, 0, 0, 8, 0);
        step(); chk("lat_enable", S_RUN, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        step(); chk("lat_count1", S_RUN, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        step(); chk("pause_enter", S_PAUSE, 2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(); chk($sformatf("pause_hold%0d", i), S_PAUSE, 2, 0, 0);
        end
        drive(1, 0, 0, 3, 3);
        step(); chk("resume", S_RUN, 2, 0, 0);
        drive(0, 0, 0, 0, 0);
        step(); chk("resume_cnt3", S_RUN, 3, 0, 0);

        // Asynchronous reset in mid-run, between clock edges
        reset = 1'b0;
        #1;
        chk("async_reset", S_IDLE, 0, 0, 0);
        #2;
        reset = 1'b1;
        step(); chk("post_reset1", S_IDLE, 0, 0, 0);
        step(); chk("post_reset2", S_IDLE, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter: CNT_W, 4, width of modulus and count.
REQ-002 Parameter: WRAP_W, 8, width of wrap target and wrap count.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset=0 forces reset state immediately.
REQ-005 start  input  1  start a new run (IDLE/DONE) or resume (PAUSE).
REQ-006 pause  input  1  freeze a run in progress.
REQ-007 stop  input  1  abort to IDLE from any state.
REQ-008 mod_m  input  CNT_W  counter modulus; 0 means 2^CNT_W.
REQ-009 n_wraps  input  WRAP_W  number of wraps per run; 0 means free-run.
REQ-010 enable_out  output  1  high exactly while state is RUN; drives an external counter enable.
REQ-011 count  output  CNT_W  internal modulo count.
REQ-012 carry_out  output  1  combinational; high when state is RUN and count equals latched modulus minus 1.
REQ-013 wraps  output  WRAP_W  completed wraps in the current run.
REQ-014 busy  output  1  high in RUN or PAUSE.
REQ-015 done  output  1  high while state is DONE.
REQ-016 state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSE, DONE; command priority SHALL be stop > pause > start.
REQ-018 stop=1 SHALL move any state to IDLE and clear count and wraps on the same edge.
REQ-019 start=1 in IDLE or DONE SHALL latch mod_m into m_lat and n_wraps into n_lat, clear count and wraps, and enter RUN on that edge.
REQ-020 mod_m and n_wraps changes outside the start-from-IDLE/DONE edge SHALL have no effect.
REQ-021 In RUN, each edge SHALL increment count; when count equals m_lat-1, count SHALL instead wrap to 0 and wraps SHALL increment.
REQ-022 An m_lat of 0 SHALL count 0..2^CNT_W-1.
REQ-023 An m_lat of 1 SHALL hold count at 0, with carry_out high every RUN cycle.
REQ-024 Latency: start sampled at edge k SHALL give enable_out=1 after edge k and count=1 after edge k+1.
REQ-025 pause=1 in RUN SHALL enter PAUSE with count and wraps frozen; carry_out SHALL be 0 in PAUSE.
REQ-026 start=1 in PAUSE SHALL resume RUN with no reload and no clearing; pause=1 in PAUSE SHALL keep PAUSE.
REQ-027 If n_lat is not 0 and carry_out=1 with wraps=n_lat-1, that edge SHALL set wraps=n_lat and count=0 and enter DONE.
REQ-028 If n_lat=0, wraps SHALL wrap modulo 2^WRAP_W and RUN SHALL continue until stop or pause.
REQ-029 DONE SHALL hold count, wraps and done until start (new run) or stop (IDLE).
REQ-030 pause or start with no applicable transition SHALL be ignored, e.g. pause in IDLE or start in RUN.
REQ-031 If pause=1 coincides with a terminal carry, pause SHALL win: the state becomes PAUSE, count wraps to 0 and wraps increments; the next resume SHALL reach DONE only on the following terminal carry.

Reset
REQ-032 reset=0 SHALL asynchronously force state=IDLE, count=0, wraps=0, m_lat=0, n_lat=0, enable_out=0, busy=0, done=0, carry_out=0.
REQ-033 Reset asserted mid-run SHALL abort the run with no done indication; after release, the block SHALL stay in IDLE until start.

Verification
REQ-034 reset=0 pulsed during RUN at count=3 -> all outputs 0 immediately, before any clock edge; IDLE after release.
REQ-035 mod_m=5, n_wraps=2, start pulse -> count 1,2,3,4,0,1,2,3,4,0; carry_out high when count=4; DONE after 10 RUN edges with wraps=2.
REQ-036 mod_m=5, n_wraps=0 -> continuous RUN; wraps=3 after 15 edges; stop -> IDLE with count=0 and wraps=0.
REQ-037 mod_m=0, n_wraps=1 -> count reaches 15, carry_out high at 15, DONE on the 16th edge.
REQ-038 pause at count=2, hold 5 cycles, then start -> count stays 2 through the pause and is 3 one edge after resume.
REQ-039 start, pause and stop asserted together in RUN -> IDLE; mod_m changed during RUN -> modulus unchanged until the next run.
